data_l1_wb_cache: RTL and testbench
===================================

DATA_L1_WB_CACHE -- requirements
Module: data_l1_wb_cache

Interface
- REQ-001 The block SHALL have parameter ADDR_W, default 16, word address width.
- REQ-002 The block SHALL have parameter DATA_W, default 16, word width in bits.
- REQ-003 The block SHALL have parameter WORDS_PER_BLOCK, default 8, words per line; power of two, ≥2.
- REQ-004 The block SHALL have parameter NUM_BLOCKS, default 2048, line count; power of two; direct-mapped.
- REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
- REQ-006 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
- REQ-007 The block SHALL have port req_valid, input, 1 bit, CPU request present.
- REQ-008 The block SHALL have port req_ready, output, 1 bit, cache accepts a request this cycle.
- REQ-009 The block SHALL have port req_write, input, 1 bit: 0 = read, 1 = write.
- REQ-010 The block SHALL have port req_addr, input, ADDR_W bits, word address.
- REQ-011 The block SHALL have port req_wdata, input, DATA_W bits, write data.
- REQ-012 The block SHALL have port resp_valid, output, 1 bit, one-cycle completion pulse for reads and writes.
- REQ-013 The block SHALL have port resp_rdata, output, DATA_W bits, read data; valid only with resp_valid and req_write=0.
- REQ-014 The block SHALL have port mem_req_valid, output, 1 bit, backing-memory beat request.
- REQ-015 The block SHALL have port mem_req_ready, input, 1 bit, memory accepts the beat.
- REQ-016 The block SHALL have port mem_req_write, output, 1 bit, beat is a write.
- REQ-017 The block SHALL have ports mem_addr, output, ADDR_W bits, and mem_wdata, output, DATA_W bits, beat address and write data.
- REQ-018 The block SHALL have ports mem_rvalid, input, 1 bit, and mem_rdata, input, DATA_W bits, read-beat return.

Function
- REQ-019 Address split SHALL be offset = low log2(WORDS_PER_BLOCK) bits, index = next log2(NUM_BLOCKS) bits, tag = remaining upper bits.
- REQ-020 Per line the block SHALL store tag, valid bit, dirty bit and WORDS_PER_BLOCK data words.
- REQ-021 FSM states SHALL be IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND; req_ready=1 only in IDLE.
- REQ-022 Handshake: req_valid&&req_ready SHALL capture req_write/addr/wdata and move IDLE→LOOKUP; inputs are ignored outside IDLE.
- REQ-023 LOOKUP hit (valid && tag match) SHALL go to RESPOND; a hit completes with resp_valid exactly 2 cycles after acceptance.
- REQ-024 Write hit SHALL update only the addressed word and set dirty; read hit SHALL return the addressed word.
- REQ-025 LOOKUP miss with valid&&dirty victim SHALL go to WRITEBACK; otherwise to REFILL.
- REQ-026 WRITEBACK SHALL issue WORDS_PER_BLOCK write beats, offsets 0..N-1 ascending, address = {victim tag, index, offset}, advancing on mem_req_valid&&mem_req_ready, then go to REFILL.
- REQ-027 REFILL SHALL issue read beats ascending, one outstanding, holding mem_req_valid until accepted and waiting for mem_rvalid before the next beat; mem_rvalid when no read is outstanding is ignored.
- REQ-028 After the last refill beat the line SHALL take the new tag, valid=1, dirty=0, then go to RESPOND (write-allocate).
- REQ-029 RESPOND SHALL apply the pending write (dirty=1) or drive read data, pulse resp_valid one cycle, return to IDLE.
- REQ-030 mem_req_valid SHALL be 0 outside WRITEBACK/REFILL; mem_addr/mem_wdata SHALL be stable while mem_req_valid=1 and not accepted.
- REQ-031 Beat counter SHALL be log2(WORDS_PER_BLOCK)+1 bits and SHALL not wrap into a spurious extra beat.

Reset
- REQ-032 While reset=0: all valid and dirty bits 0, FSM IDLE, beat counter 0, resp_valid=0, resp_rdata=0, mem_req_valid=0, mem_req_write=0, mem_addr=0, mem_wdata=0; req_ready=1 (requests ignored while reset=0); data/tag arrays not cleared.
- REQ-033 Reset mid-WRITEBACK/REFILL SHALL abandon the transaction immediately with no resp_valid; the partially refilled line stays invalid.

Verification (defaults: offset [2:0], index [13:3], tag [15:14])
- REQ-034 Cold read 0x0010 -> 8 read beats at 0x0010..0x0017 returning 0x1000..0x1007; one resp_valid, resp_rdata=0x1000.
- REQ-035 Then read 0x0013 -> hit, no mem beats, resp_valid 2 cycles after acceptance, resp_rdata=0x1003.
- REQ-036 Write 0x0012=0xBEEF then read 0x8010 -> 8 write beats to 0x0010..0x0017 with word 2=0xBEEF, others 0x100x, then 8 read beats at 0x8010..0x8017.
- REQ-037 Cold write 0x4021=0x55AA -> refill 0x4020..0x4027 only (no writeback), then read 0x4021 hits with 0x55AA.
- REQ-038 mem_req_ready held 0 for 5 cycles during refill -> mem_addr/mem_req_valid stable, no beat skipped or repeated.
- REQ-039 reset=0 after 3rd refill beat, then read same address -> full 8-beat refill from offset 0, no stale resp_valid.

Source files
------------

// File: rtl/data_l1_wb_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a
// single-beat-at-a-time backing-memory port.
module data_l1_wb_cache #(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned NUM_BLOCKS      = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned IDX_W = $clog2(NUM_BLOCKS);
  localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned CNT_W = OFF_W + 1;
  localparam int unsigned LAST  = WORDS_PER_BLOCK - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND
  } state_t;

  state_t            state;
  logic              req_write_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [CNT_W-1:0]  beat;
  logic              outstanding;
  logic [NUM_BLOCKS-1:0] valid_bits;
  logic [NUM_BLOCKS-1:0] dirty_bits;

  logic [TAG_W-1:0]  tag_mem  [NUM_BLOCKS];
  logic [DATA_W-1:0] data_mem [NUM_BLOCKS*WORDS_PER_BLOCK];

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [CNT_W-1:0]  next_beat;
  logic [OFF_W-1:0]  beat_off;
  logic [OFF_W-1:0]  next_off;
  logic              beat_last;
  logic              line_hit;
  logic              fill_fire;
  logic              wr_fire;

  assign req_off   = req_addr_q[OFF_W-1:0];
  assign req_idx   = req_addr_q[OFF_W +: IDX_W];
  assign req_tag   = req_addr_q[ADDR_W-1 -: TAG_W];
  assign next_beat = beat + CNT_W'(1);
  assign beat_off  = beat[OFF_W-1:0];
  assign next_off  = next_beat[OFF_W-1:0];
  assign beat_last = (beat == CNT_W'(LAST));
  assign line_hit  = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);
  assign fill_fire = (state == S_REFILL) && outstanding && mem_rvalid;
  assign wr_fire   = (state == S_RESPOND) && req_write_q;

  // Data and tag arrays: refill beats, pending-write merge, tag install on last beat.
  always_ff @(posedge clk) begin
    if (fill_fire) begin
      data_mem[{req_idx, beat_off}] <= mem_rdata;
    end else if (wr_fire) begin
      data_mem[{req_idx, req_off}] <= req_wdata_q;
    end
    if (fill_fire && beat_last) begin
      tag_mem[req_idx] <= req_tag;
    end
  end

  // Control FSM with registered handshake, response and memory-beat outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      req_ready     <= 1'b1;
      req_write_q   <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      beat          <= '0;
      outstanding   <= 1'b0;
      valid_bits    <= '0;
      dirty_bits    <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_write_q <= req_write;
            req_addr_q  <= req_addr;
            req_wdata_q <= req_wdata;
            req_ready   <= 1'b0;
            state       <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          beat        <= '0;
          outstanding <= 1'b0;
          if (line_hit) begin
            state <= S_RESPOND;
          end else if (valid_bits[req_idx] && dirty_bits[req_idx]) begin
            mem_req_valid <= 1'b1;
            mem_req_write <= 1'b1;
            mem_addr      <= {tag_mem[req_idx], req_idx, OFF_W'(0)};
            mem_wdata     <= data_mem[{req_idx, OFF_W'(0)}];
            state         <= S_WRITEBACK;
          end else begin
            // Line is invalid until the final refill beat lands.
            valid_bits[req_idx] <= 1'b0;
            dirty_bits[req_idx] <= 1'b0;
            mem_req_valid <= 1'b1;
            mem_req_write <= 1'b0;
            mem_addr      <= {req_tag, req_idx, OFF_W'(0)};
            state         <= S_REFILL;
          end
        end
        S_WRITEBACK: begin
          if (mem_req_ready) begin
            if (beat_last) begin
              valid_bits[req_idx] <= 1'b0;
              dirty_bits[req_idx] <= 1'b0;
              beat          <= '0;
              mem_req_write <= 1'b0;
              mem_addr      <= {req_tag, req_idx, OFF_W'(0)};
              state         <= S_REFILL;
            end else begin
              beat      <= next_beat;
              mem_addr  <= {tag_mem[req_idx], req_idx, next_off};
              mem_wdata <= data_mem[{req_idx, next_off}];
            end
          end
        end
        S_REFILL: begin
          if (mem_req_valid && mem_req_ready) begin
            mem_req_valid <= 1'b0;
            outstanding   <= 1'b1;
          end else if (fill_fire) begin
            outstanding <= 1'b0;
            if (beat_last) begin
              valid_bits[req_idx] <= 1'b1;
              dirty_bits[req_idx] <= 1'b0;
              state               <= S_RESPOND;
            end else begin
              beat          <= next_beat;
              mem_req_valid <= 1'b1;
              mem_addr      <= {req_tag, req_idx, next_off};
            end
          end
        end
        S_RESPOND: begin
          resp_valid <= 1'b1;
          if (req_write_q) begin
            dirty_bits[req_idx] <= 1'b1;
          end else begin
            resp_rdata <= data_mem[{req_idx, req_off}];
          end
          beat      <= '0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_l1_wb_cache.sv
// Directed, table-driven bench for data_l1_wb_cache with a backing-memory responder.
module tb_data_l1_wb_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic        mem_req_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = 16'h0;

  data_l1_wb_cache dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_wb;
    int          exp_rd;
    logic [15:0] wb_base;
    logic [15:0] rd_base;
    logic [15:0] wb_dbase;
    int          wb_sel;
    logic [15:0] wb_sel_val;
    logic        stall;
  } vec_t;

  // Responder-owned state
  beat_t       log_q[$];
  logic [15:0] wr_model [int];
  logic        pend_read = 1'b0;
  logic [15:0] pend_data = 16'h0;
  int          stall_left = 0;
  int          armed_at = -1;
  int          stall_cycles = 0;
  int          pulse_cnt = 0;
  int          stab_viol = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b1;
  logic [15:0] prev_addr = 16'h0;
  logic [15:0] prev_wdata = 16'h0;

  // Main-owned state
  int   log_start = 0;
  logic stall_en = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[12];

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    if (wr_model.exists(int'(a))) return wr_model[int'(a)];
    return 16'(a + 16'h0FF0);
  endfunction

  // Backing memory: decides ready for the coming edge, logs accepted beats, returns read data a cycle later.
  always @(negedge clk) begin
    if (resp_valid) pulse_cnt++;
    if (!reset) begin
      pend_read     = 1'b0;
      mem_rvalid    = 1'b0;
      mem_req_ready = 1'b1;
      prev_valid    = 1'b0;
      stall_left    = 0;
    end else begin
      mem_rvalid = 1'b0;
      if (pend_read) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_data;
        pend_read  = 1'b0;
      end
      if (prev_valid && !prev_ready &&
          (!mem_req_valid || mem_addr != prev_addr || mem_wdata != prev_wdata))
        stab_viol++;
      if (stall_en && armed_at != log_start && mem_req_valid &&
          (log_q.size() - log_start) == 2) begin
        stall_left = 5;
        armed_at   = log_start;
      end
      if (stall_left > 0) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        mem_req_ready = 1'b1;
      end
      if (mem_req_valid && !mem_req_ready) stall_cycles++;
      if (mem_req_valid && mem_req_ready) begin
        log_q.push_back('{mem_req_write, mem_addr, mem_wdata});
        if (mem_req_write) begin
          wr_model[int'(mem_addr)] = mem_wdata;
        end else begin
          pend_read = 1'b1;
          pend_data = model_rd(mem_addr);
        end
      end
      prev_valid = mem_req_valid;
      prev_ready = mem_req_ready;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Issue one request and check response, latency and the exact memory beat sequence.
  task automatic run_vec(input vec_t v, input int n);
    int          cyc;
    logic        got;
    int          p0, s0, v0, nb, j;
    logic [15:0] ea, ed;
    @(negedge clk);
    log_start = log_q.size();
    p0 = pulse_cnt;
    s0 = stall_cycles;
    v0 = stab_viol;
    stall_en = v.stall;
    chk($sformatf("v%0d_req_ready", n), 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (resp_valid) got = 1'b1;
    end
    chk($sformatf("v%0d_resp_seen", n), 32'(got), 32'd1);
    if (v.exp_wb == 0 && v.exp_rd == 0)
      chk($sformatf("v%0d_hit_latency", n), 32'(cyc), 32'd2);
    if (!v.write)
      chk($sformatf("v%0d_rdata", n), 32'(resp_rdata), 32'(v.exp_rdata));
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_resp_pulses", n), 32'(pulse_cnt - p0), 32'd1);
    nb = log_q.size() - log_start;
    chk($sformatf("v%0d_beat_count", n), 32'(nb), 32'(v.exp_wb + v.exp_rd));
    for (int i = 0; i < nb; i++) begin
      j = log_start + i;
      if (i < v.exp_wb) begin
        ea = 16'(v.wb_base + 16'(i));
        ed = (i == v.wb_sel) ? v.wb_sel_val : 16'(v.wb_dbase + 16'(i));
        chk($sformatf("v%0d_wb%0d_kind", n, i), 32'(log_q[j].w), 32'd1);
        chk($sformatf("v%0d_wb%0d_addr", n, i), 32'(log_q[j].addr), 32'(ea));
        chk($sformatf("v%0d_wb%0d_data", n, i), 32'(log_q[j].data), 32'(ed));
      end else begin
        ea = 16'(v.rd_base + 16'(i - v.exp_wb));
        chk($sformatf("v%0d_rd%0d_kind", n, i), 32'(log_q[j].w), 32'd0);
        chk($sformatf("v%0d_rd%0d_addr", n, i), 32'(log_q[j].addr), 32'(ea));
      end
    end
    if (v.stall) begin
      chk($sformatf("v%0d_stall_cycles", n), 32'(stall_cycles - s0), 32'd5);
      chk($sformatf("v%0d_stable_beat", n), 32'(stab_viol - v0), 32'd0);
    end
    stall_en = 1'b0;
  endtask

  initial begin
    int   cyc;
    int   p0;
    vec_t vr;

    //           wr    addr      wdata     rdata     wb rd wb_base   rd_base   wb_dbase  sel sel_val  stall
    vecs[0]  = '{1'b0, 16'h0010, 16'h0000, 16'h1000, 0, 8, 16'h0000, 16'h0010, 16'h0000, -1, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 16'h0013, 16'h0000, 16'h1003, 0, 0, 16'h0000, 16'h0000, 16'h0000, -1, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 16'h0012, 16'hBEEF, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, -1, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 16'h8010, 16'h0000, 16'h9000, 8, 8, 16'h0010, 16'h8010, 16'h1000,  2, 16'hBEEF, 1'b0};
    vecs[4]  = '{1'b1, 16'h4021, 16'h55AA, 16'h0000, 0, 8, 16'h0000, 16'h4020, 16'h0000, -1, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 16'h4021, 16'h0000, 16'h55AA, 0, 0, 16'h0000, 16'h0000, 16'h0000, -1, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 16'h0012, 16'h0000, 16'hBEEF, 0, 8, 16'h0000, 16'h0010, 16'h0000, -1, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 16'h0017, 16'h1234, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, -1, 16'h0000, 1'b0};
    vecs[8]  = '{1'b0, 16'h0017, 16'h0000, 16'h1234, 0, 0, 16'h0000, 16'h0000, 16'h0000, -1, 16'h0000, 1'b0};
    vecs[9]  = '{1'b0, 16'h3FFF, 16'h0000, 16'h4FEF, 0, 8, 16'h0000, 16'h3FF8, 16'h0000, -1, 16'h0000, 1'b0};
    vecs[10] = '{1'b0, 16'hFFF8, 16'h0000, 16'h0FE8, 0, 8, 16'h0000, 16'hFFF8, 16'h0000, -1, 16'h0000, 1'b0};
    vecs[11] = '{1'b0, 16'h1230, 16'h0000, 16'h2220, 0, 8, 16'h0000, 16'h1230, 16'h0000, -1, 16'h0000, 1'b1};
    vr       = '{1'b0, 16'h246A, 16'h0000, 16'h345A, 0, 8, 16'h0000, 16'h2468, 16'h0000, -1, 16'h0000, 1'b0};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0;
    req_wdata = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_req_write", 32'(mem_req_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Abandon a refill after its third beat; the line must refill from scratch.
    @(negedge clk);
    log_start = log_q.size();
    p0 = pulse_cnt;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h246A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    while ((log_q.size() - log_start) < 3 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_three_beats", 32'(log_q.size() - log_start), 32'd3);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_resp", 32'(pulse_cnt - p0), 32'd0);
    run_vec(vr, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
